spi_flash_responder: RTL and testbench

Synthesizable SPI-flash responder, the target-side counterpart of the bootloader's SPI flash master. It answers the small command subset the bootloader issues (JEDEC ID, status, read, power-down, release power-down) from an internal byte memory. This lets the bootloader's flash path be exercised in simulation and on a second FPGA without a real flash device. It runs entirely in the `clk_48mhz` domain and oversamples the SPI pins.

---
 rtl/spi_flash_responder.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_responder
// Purpose  : SPI-flash target model answering JEDEC ID (0x9F), read status
//            (0x05), read data (0x03), deep power-down (0xB9) and release
//            power-down (0xAB) from an internal preloadable byte memory.
//            The SPI pins are oversampled in the clk_48mhz domain.
// Ports    : clk_48mhz    - sole clock, rising edge
//            rst_n        - asynchronous active-low reset
//            spi_cs       - chip select, active low (asynchronous)
//            spi_sck      - SPI clock, mode 0 (asynchronous)
//            spi_mosi     - master-out data, MSB first (asynchronous)
//            spi_miso     - responder data, MSB first, idles high
//            mem_we       - preload write strobe
//            mem_addr     - preload address
//            mem_wdata    - preload data
//            last_opcode  - last complete opcode byte received
//            powered_down - deep power-down flag
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
    parameter int          MEM_BYTES = 256,
    parameter logic [23:0] JEDEC_ID  = 24'h1F8501
) (
    input  logic                         clk_48mhz,
    input  logic                         rst_n,
    input  logic                         spi_cs,
    input  logic                         spi_sck,
    input  logic                         spi_mosi,
    output logic                         spi_miso,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_BYTES)-1:0] mem_addr,
    input  logic [7:0]                   mem_wdata,
    output logic [7:0]                   last_opcode,
    output logic                         powered_down
);

    localparam int         c_addr_w     = $clog2(MEM_BYTES);
    localparam logic [7:0] c_op_jedec   = 8'h9F;
    localparam logic [7:0] c_op_status  = 8'h05;
    localparam logic [7:0] c_op_read    = 8'h03;
    localparam logic [7:0] c_op_pdown   = 8'hB9;
    localparam logic [7:0] c_op_release = 8'hAB;
    localparam logic [c_addr_w-1:0] c_addr_one = {{(c_addr_w-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_IGNORE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RESP_JEDEC  = 2'd0,
        RESP_STATUS = 2'd1,
        RESP_READ   = 2'd2
    } resp_t;

    // ------------------------------------------------------------------
    // Pin synchronizers and edge detection
    // ------------------------------------------------------------------
    logic r_cs_meta,   r_cs_sync,   r_cs_prev;
    logic r_sck_meta,  r_sck_sync,  r_sck_prev;
    logic r_mosi_meta, r_mosi_sync;
    // r_warm[1] marks the point where the sync stage holds real pin data
    // rather than its reset value.
    logic [1:0] r_warm;

    always_ff @(posedge clk_48mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_prev   <= 1'b1;
            r_sck_meta  <= 1'b0;
            r_sck_sync  <= 1'b0;
            r_sck_prev  <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_warm      <= 2'b00;
        end else begin
            r_cs_meta   <= spi_cs;
            r_cs_sync   <= r_cs_meta;
            r_cs_prev   <= r_cs_sync;
            r_sck_meta  <= spi_sck;
            r_sck_sync  <= r_sck_meta;
            r_sck_prev  <= r_sck_sync;
            r_mosi_meta <= spi_mosi;
            r_mosi_sync <= r_mosi_meta;
            r_warm      <= {r_warm[0], 1'b1};
        end
    end

    logic w_cs_rise, w_cs_fall, w_sck_rise, w_sck_fall;

    assign w_cs_rise  =  r_cs_sync & ~r_cs_prev;
    assign w_cs_fall  = ~r_cs_sync &  r_cs_prev;
    assign w_sck_rise =  r_sck_sync & ~r_sck_prev;
    assign w_sck_fall = ~r_sck_sync &  r_sck_prev;

    // ------------------------------------------------------------------
    // Byte memory: preload write port, registered read port for DATA
    // ------------------------------------------------------------------
    logic [7:0]          r_mem [MEM_BYTES];
    logic [7:0]          r_mem_q;
    logic [c_addr_w-1:0] r_rd_addr;

    always_ff @(posedge clk_48mhz) begin
        if (mem_we) begin
            r_mem[mem_addr] <= mem_wdata;
        end
        r_mem_q <= r_mem[r_rd_addr];
    end

    // ------------------------------------------------------------------
    // Protocol state machine
    // ------------------------------------------------------------------
    state_t              r_state;
    resp_t               r_resp;
    logic [4:0]          r_bit_cnt;     // bit index within opcode / address
    logic [3:0]          r_total;       // bits clocked this frame, saturating
    logic [6:0]          r_op_shift;
    logic [c_addr_w-1:0] r_addr_sr;     // only the low address bits matter
    logic [6:0]          r_tx_shift;
    logic [2:0]          r_tx_cnt;      // 0 = next fall starts a new byte
    logic [1:0]          r_byte_idx;    // response byte count, saturating
    logic                r_pd_set;
    logic                r_pd_clr;
    logic                r_armed;
    logic                r_miso;
    logic [7:0]          r_last_opcode;
    logic                r_powered_down;

    logic [7:0] w_opcode;
    logic [7:0] w_next_byte;

    assign w_opcode = {r_op_shift, r_mosi_sync};

    always_comb begin
        w_next_byte = 8'h00;
        case (r_resp)
            RESP_JEDEC: begin
                case (r_byte_idx)
                    2'd0:    w_next_byte = JEDEC_ID[23:16];
                    2'd1:    w_next_byte = JEDEC_ID[15:8];
                    2'd2:    w_next_byte = JEDEC_ID[7:0];
                    default: w_next_byte = 8'h00;
                endcase
            end
            RESP_READ:   w_next_byte = r_mem_q;
            default:     w_next_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk_48mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_resp         <= RESP_STATUS;
            r_bit_cnt      <= 5'd0;
            r_total        <= 4'd0;
            r_op_shift     <= 7'd0;
            r_addr_sr      <= '0;
            r_rd_addr      <= '0;
            r_tx_shift     <= 7'd0;
            r_tx_cnt       <= 3'd0;
            r_byte_idx     <= 2'd0;
            r_pd_set       <= 1'b0;
            r_pd_clr       <= 1'b0;
            r_armed        <= 1'b0;
            r_miso         <= 1'b1;
            r_last_opcode  <= 8'h00;
            r_powered_down <= 1'b0;
        end else begin
            // A frame may only start once CS has been seen high after reset,
            // so a master caught mid-transaction is ignored until it deselects.
            if (r_warm[1] && r_cs_sync) begin
                r_armed <= 1'b1;
            end

            if (w_cs_rise) begin
                r_state  <= ST_IDLE;
                r_miso   <= 1'b1;
                r_pd_set <= 1'b0;
                r_pd_clr <= 1'b0;
                if (r_state == ST_IGNORE) begin
                    // Power-down only when the frame was exactly the opcode.
                    if (r_pd_set && (r_total == 4'd8)) begin
                        r_powered_down <= 1'b1;
                    end
                    if (r_pd_clr && (r_total >= 4'd8)) begin
                        r_powered_down <= 1'b0;
                    end
                end
            end else begin
                if (w_sck_rise && (r_state != ST_IDLE) && (r_total != 4'd15)) begin
                    r_total <= r_total + 4'd1;
                end

                case (r_state)
                    ST_IDLE: begin
                        r_miso <= 1'b1;
                        if (w_cs_fall && r_armed) begin
                            r_state   <= ST_CMD;
                            r_bit_cnt <= 5'd0;
                            r_total   <= 4'd0;
                            r_pd_set  <= 1'b0;
                            r_pd_clr  <= 1'b0;
                        end
                    end

                    ST_CMD: begin
                        if (w_sck_rise) begin
                            r_op_shift <= w_opcode[6:0];
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt     <= 5'd0;
                                r_last_opcode <= w_opcode;
                                r_tx_cnt      <= 3'd0;
                                r_byte_idx    <= 2'd0;
                                if (r_powered_down) begin
                                    r_state  <= ST_IGNORE;
                                    r_pd_clr <= (w_opcode == c_op_release);
                                end else begin
                                    case (w_opcode)
                                        c_op_jedec: begin
                                            r_state <= ST_DATA;
                                            r_resp  <= RESP_JEDEC;
                                        end
                                        c_op_status: begin
                                            r_state <= ST_DATA;
                                            r_resp  <= RESP_STATUS;
                                        end
                                        c_op_read: begin
                                            r_state <= ST_ADDR;
                                            r_resp  <= RESP_READ;
                                        end
                                        c_op_pdown: begin
                                            r_state  <= ST_IGNORE;
                                            r_pd_set <= 1'b1;
                                        end
                                        c_op_release: begin
                                            r_state  <= ST_IGNORE;
                                            r_pd_clr <= 1'b1;
                                        end
                                        default: begin
                                            r_state <= ST_IGNORE;
                                        end
                                    endcase
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end

                    ST_ADDR: begin
                        if (w_sck_rise) begin
                            r_addr_sr <= {r_addr_sr[c_addr_w-2:0], r_mosi_sync};
                            if (r_bit_cnt == 5'd23) begin
                                r_bit_cnt <= 5'd0;
                                r_state   <= ST_DATA;
                                // Starting the fetch here leaves the first byte
                                // ready long before the next SCK fall.
                                r_rd_addr <= {r_addr_sr[c_addr_w-2:0], r_mosi_sync};
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end

                    ST_DATA: begin
                        if (w_sck_fall) begin
                            if (r_tx_cnt == 3'd0) begin
                                r_miso     <= w_next_byte[7];
                                r_tx_shift <= w_next_byte[6:0];
                                if (r_byte_idx != 2'd3) begin
                                    r_byte_idx <= r_byte_idx + 2'd1;
                                end
                                // Prefetch the following byte while this one
                                // shifts out; the address wraps naturally.
                                if (r_resp == RESP_READ) begin
                                    r_rd_addr <= r_rd_addr + c_addr_one;
                                end
                            end else begin
                                r_miso     <= r_tx_shift[6];
                                r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                            end
                            r_tx_cnt <= r_tx_cnt + 3'd1;
                        end
                    end

                    ST_IGNORE: begin
                        r_miso <= 1'b1;
                    end

                    default: begin
                        r_state <= ST_IDLE;
                        r_miso  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign spi_miso     = r_miso;
    assign last_opcode  = r_last_opcode;
    assign powered_down = r_powered_down;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_flash_responder
// Purpose  : Self-checking bench for spi_flash_responder: directed table of
//            transactions, reset corner cases, then random transactions
//            checked against a byte-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_responder;

    localparam int          MEM_BYTES = 256;
    localparam logic [23:0] JEDEC     = 24'h1F8501;
    localparam int          HALF      = 6;

    logic       clk_48mhz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       spi_cs    = 1'b1;
    logic       spi_sck   = 1'b0;
    logic       spi_mosi  = 1'b0;
    logic       mem_we    = 1'b0;
    logic [7:0] mem_addr  = 8'h00;
    logic [7:0] mem_wdata = 8'h00;
    logic       spi_miso;
    logic [7:0] last_opcode;
    logic       powered_down;

    spi_flash_responder #(
        .MEM_BYTES (MEM_BYTES),
        .JEDEC_ID  (JEDEC)
    ) dut (
        .clk_48mhz    (clk_48mhz),
        .rst_n        (rst_n),
        .spi_cs       (spi_cs),
        .spi_sck      (spi_sck),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .last_opcode  (last_opcode),
        .powered_down (powered_down)
    );

    always #10 clk_48mhz = ~clk_48mhz;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem_model [MEM_BYTES];
    logic       pd_model   = 1'b0;
    logic [7:0] last_model = 8'h00;
    logic [7:0] rx_bytes [16];

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        int          ndata;
        int          cut;
        logic [39:0] exp_data;
        logic        exp_pd;
        logic [7:0]  exp_last;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_48mhz);
    endtask

    task automatic mem_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk_48mhz);
        mem_we    = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        @(negedge clk_48mhz);
        mem_we    = 1'b0;
        mem_model[a] = d;
    endtask

    // One mode-0 bit: MISO is sampled just before the rising edge.
    task automatic spi_bit(input logic b, output logic r);
        spi_mosi = b;
        wait_cycles(HALF);
        r = spi_miso;
        spi_sck = 1'b1;
        wait_cycles(HALF);
        spi_sck = 1'b0;
    endtask

    task automatic run_txn(input logic [7:0] op, input logic [23:0] addr,
                           input int ndata, input int cut, output int nbits);
        logic [7:0] txb [16];
        logic       r;
        int         nb;
        int         hb;
        hb = (op == 8'h03) ? 4 : 1;
        nb = hb + ndata;
        txb[0] = op;
        txb[1] = addr[23:16];
        txb[2] = addr[15:8];
        txb[3] = addr[7:0];
        for (int i = hb; i < 16; i++) txb[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) rx_bytes[i] = 8'h00;
        nbits = nb * 8;
        if (cut > 0 && cut < nbits) nbits = cut;
        spi_cs = 1'b0;
        wait_cycles(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(txb[i / 8][7 - (i % 8)], r);
            rx_bytes[i / 8][7 - (i % 8)] = r;
        end
        wait_cycles(HALF);
        spi_cs = 1'b1;
        wait_cycles(10);
    endtask

    // Response byte k of a frame, from the command semantics alone.
    function automatic logic [7:0] model_byte(input logic [7:0] op, input logic [23:0] addr,
                                              input logic pd, input int k);
        int a;
        if (k == 0) return 8'hFF;
        if (pd) return 8'hFF;
        case (op)
            8'h9F:   return (k <= 3) ? JEDEC[8 * (3 - k) +: 8] : 8'h00;
            8'h05:   return 8'h00;
            8'h03: begin
                if (k < 4) return 8'hFF;
                a = (int'(addr % MEM_BYTES) + k - 4) % MEM_BYTES;
                return mem_model[a];
            end
            default: return 8'hFF;
        endcase
    endfunction

    task automatic model_update(input logic [7:0] op, input int nbits);
        if (nbits >= 8) begin
            last_model = op;
            if (op == 8'hAB) pd_model = 1'b0;
            else if (op == 8'hB9 && !pd_model && nbits == 8) pd_model = 1'b1;
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int         nbits;
        int         hb;
        logic       r;
        logic [7:0] op;
        logic [15:0] junk_rx;

        vecs[0] = '{8'h9F, 24'h000000, 5, 0,  40'h1F85010000, 1'b0, 8'h9F};
        vecs[1] = '{8'h03, 24'h0000FE, 4, 0,  40'h5B5AA5A400, 1'b0, 8'h03};
        vecs[2] = '{8'h03, 24'h000000, 0, 20, 40'h0000000000, 1'b0, 8'h03};
        vecs[3] = '{8'h05, 24'h000000, 2, 0,  40'h0000000000, 1'b0, 8'h05};
        vecs[4] = '{8'hB9, 24'h000000, 0, 0,  40'h0000000000, 1'b1, 8'hB9};
        vecs[5] = '{8'h9F, 24'h000000, 3, 0,  40'hFFFFFF0000, 1'b1, 8'h9F};
        vecs[6] = '{8'hAB, 24'h000000, 0, 0,  40'h0000000000, 1'b0, 8'hAB};
        vecs[7] = '{8'h9F, 24'h000000, 1, 0,  40'h1F00000000, 1'b0, 8'h9F};
        vecs[8] = '{8'hB9, 24'h000000, 0, 7,  40'h0000000000, 1'b0, 8'h9F};
        vecs[9] = '{8'h05, 24'h000000, 1, 0,  40'h0000000000, 1'b0, 8'h05};

        // Reset values
        wait_cycles(5);
        check("reset_miso", 32'(spi_miso), 32'd1);
        check("reset_last_opcode", 32'(last_opcode), 32'h00);
        check("reset_powered_down", 32'(powered_down), 32'd0);
        rst_n = 1'b1;
        wait_cycles(5);

        for (int i = 0; i < MEM_BYTES; i++) mem_write(8'(i), 8'(i) ^ 8'hA5);

        // Directed table
        for (int v = 0; v < 10; v++) begin
            run_txn(vecs[v].op, vecs[v].addr, vecs[v].ndata, vecs[v].cut, nbits);
            hb = (vecs[v].op == 8'h03) ? 4 : 1;
            if (nbits >= 8) check($sformatf("vec%0d_cmd_phase", v), 32'(rx_bytes[0]), 32'hFF);
            for (int k = 0; k < vecs[v].ndata; k++)
                check($sformatf("vec%0d_data%0d", v, k), 32'(rx_bytes[hb + k]),
                      32'(vecs[v].exp_data[39 - 8 * k -: 8]));
            check($sformatf("vec%0d_powered_down", v), 32'(powered_down), 32'(vecs[v].exp_pd));
            check($sformatf("vec%0d_last_opcode", v), 32'(last_opcode), 32'(vecs[v].exp_last));
            check($sformatf("vec%0d_miso_idle", v), 32'(spi_miso), 32'd1);
        end

        // Reset in byte 2 of a read, then master still mid-frame after release
        spi_cs = 1'b0;
        wait_cycles(HALF);
        for (int i = 0; i < 32; i++) begin
            op = (i < 8) ? 8'h03 : ((i < 24) ? 8'h00 : 8'h10);
            spi_bit(op[7 - (i % 8)], r);
        end
        for (int i = 0; i < 8; i++) begin
            spi_bit(1'b0, r);
            rx_bytes[0][7 - i] = r;
        end
        check("rst_seq_byte1", 32'(rx_bytes[0]), 32'hB5);
        spi_bit(1'b0, r);
        check("rst_seq_byte2_bit7", 32'(r), 32'd1);
        wait_cycles(HALF);
        check("rst_seq_miso_before", 32'(spi_miso), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_seq_miso", 32'(spi_miso), 32'd1);
        check("rst_seq_last_opcode", 32'(last_opcode), 32'h00);
        check("rst_seq_powered_down", 32'(powered_down), 32'd0);
        wait_cycles(4);
        rst_n = 1'b1;
        wait_cycles(HALF);
        for (int i = 0; i < 16; i++) begin
            op = (i < 8) ? 8'h9F : 8'h00;
            spi_bit(op[7 - (i % 8)], r);
            junk_rx[15 - i] = r;
        end
        check("post_rst_midframe_miso", 32'(junk_rx), 32'hFFFF);
        check("post_rst_midframe_last", 32'(last_opcode), 32'h00);
        wait_cycles(HALF);
        spi_cs = 1'b1;
        wait_cycles(10);
        run_txn(8'h9F, 24'h0, 3, 0, nbits);
        check("post_rst_jedec0", 32'(rx_bytes[1]), 32'h1F);
        check("post_rst_jedec1", 32'(rx_bytes[2]), 32'h85);
        check("post_rst_jedec2", 32'(rx_bytes[3]), 32'h01);
        check("post_rst_last", 32'(last_opcode), 32'h9F);

        // Reset clears a set power-down flag
        run_txn(8'hB9, 24'h0, 0, 0, nbits);
        check("pd_before_reset", 32'(powered_down), 32'd1);
        rst_n = 1'b0;
        #1;
        check("pd_after_reset", 32'(powered_down), 32'd0);
        wait_cycles(4);
        rst_n = 1'b1;
        wait_cycles(6);
        pd_model   = 1'b0;
        last_model = 8'h00;

        // Random transactions against the reference model
        for (int t = 0; t < 40; t++) begin
            int          sel;
            int          ndata;
            int          cut;
            int          total;
            logic [23:0] addr;
            logic        pd_before;
            if ($urandom_range(0, 3) == 0) mem_write(8'($urandom), 8'($urandom));
            sel = $urandom_range(0, 7);
            case (sel)
                0:       op = 8'h9F;
                1:       op = 8'h05;
                2, 3:    op = 8'h03;
                4:       op = 8'hB9;
                5:       op = 8'hAB;
                default: op = 8'($urandom);
            endcase
            addr  = 24'($urandom);
            ndata = $urandom_range(0, 4);
            if ((op == 8'hB9 || op == 8'hAB) && $urandom_range(0, 1) == 1) ndata = 0;
            total = ((op == 8'h03) ? 32 : 8) + 8 * ndata;
            cut   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, total - 1) : 0;
            pd_before = pd_model;
            run_txn(op, addr, ndata, cut, nbits);
            for (int k = 0; k < nbits / 8; k++)
                check($sformatf("rnd%0d_op%02h_byte%0d", t, op, k), 32'(rx_bytes[k]),
                      32'(model_byte(op, addr, pd_before && op != 8'hAB, k)));
            model_update(op, nbits);
            check($sformatf("rnd%0d_powered_down", t), 32'(powered_down), 32'(pd_model));
            check($sformatf("rnd%0d_last_opcode", t), 32'(last_opcode), 32'(last_model));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
